// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
// Opcode and ALU-operation constants are 3 and 2 bits wide; wider opcode buses are range-checked by the decoder.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    CLS_MEM,
    CLS_ALU,
    CLS_BRANCH,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [2:0] OP_SB  = 3'd0;
  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_CPY = 3'd5;
  localparam logic [2:0] OP_SL  = 3'd6;
  localparam logic [2:0] OP_BNE = 3'd7;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;
  localparam logic [1:0] ALU_CMP = 2'b11;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class plus the ALU-side controls it implies.
// Any opcode with a bit set above bit 2 is classed as illegal.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [1:0]          op_class,
  output logic [1:0]          alu_op,
  output logic                shift,
  output logic                copy,
  output logic                load
);

  logic upper_nz;

  generate
    if (OPCODE_W > 3) begin : g_wide
      assign upper_nz = |opcode[OPCODE_W-1:3];
    end else begin : g_narrow
      assign upper_nz = 1'b0;
    end
  endgenerate

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    op_class = CLS_ILLEGAL;
    alu_op   = ALU_AND;
    shift    = 1'b0;
    copy     = 1'b0;
    load     = 1'b0;
    if (!upper_nz) begin
      unique case (opcode[2:0])
        OP_SB:  op_class = CLS_MEM;
        OP_LB: begin
          op_class = CLS_MEM;
          load     = 1'b1;
        end
        OP_ADD: begin
          op_class = CLS_ALU;
          alu_op   = ALU_ADD;
        end
        OP_AND: op_class = CLS_ALU;
        OP_XOR: begin
          op_class = CLS_ALU;
          alu_op   = ALU_XOR;
        end
        OP_CPY: begin
          op_class = CLS_ALU;
          copy     = 1'b1;
        end
        OP_SL: begin
          op_class = CLS_ALU;
          shift    = 1'b1;
        end
        OP_BNE: begin
          op_class = CLS_BRANCH;
          alu_op   = ALU_CMP;
        end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl_seq.sv
// Multi-cycle control sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives the per-phase datapath strobes and keeps a saturating busy-cycle counter.
module multicycle_ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int ALUOP_W  = 2,
  parameter int CYC_W    = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Halt,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                BranchTaken,
  input  logic                MemReady,
  output logic                IrWrite,
  output logic                PcWrite,
  output logic                PcSrc,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                Shift,
  output logic                Copy,
  output logic                Load,
  output logic                ReadMem,
  output logic                WriteMem,
  output logic                WriteReg,
  output logic                Illegal,
  output logic                Busy,
  output logic                Done,
  output logic [CYC_W-1:0]    CycleCount
);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;

  logic [OPCODE_W-1:0] dec_opcode;
  logic [1:0]          dec_class;
  logic [1:0]          dec_alu_op;
  logic                dec_shift;
  logic                dec_copy;
  logic                dec_load;
  op_class_t           cls;
  logic [1:0]          alu_op;
  logic                busy;

  // The IR is loaded at the end of FETCH, so in DECODE its field is decoded directly;
  // from EXEC onward only the latched copy matters and later IR changes are ignored.
  assign dec_opcode = (state_q == DECODE) ? Opcode : opcode_q;

  ctrl_decode #(
    .OPCODE_W(OPCODE_W)
  ) u_decode (
    .opcode  (dec_opcode),
    .op_class(dec_class),
    .alu_op  (dec_alu_op),
    .shift   (dec_shift),
    .copy    (dec_copy),
    .load    (dec_load)
  );

  assign cls  = op_class_t'(dec_class);
  assign busy = !((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments, so every flop samples the pre-edge values of the others.
    if (Reset) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cyc_q    <= cyc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    cyc_d    = cyc_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = FETCH;
          cyc_d   = '0;
        end
      end
      FETCH:  state_d = Halt ? DONE : DECODE;
      DECODE: begin
        opcode_d = Opcode;
        state_d  = (cls == CLS_ILLEGAL) ? FETCH : EXEC;
      end
      EXEC: begin
        case (cls)
          CLS_MEM: state_d = MEM;
          CLS_ALU: state_d = WB;
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        if (MemReady) state_d = dec_load ? WB : FETCH;
      end
      WB:      state_d = FETCH;
      default: state_d = IDLE;
    endcase
    // Counts busy cycles only; holds at all-ones rather than wrapping.
    if (busy && (cyc_q != '1)) cyc_d = cyc_q + 1'b1;
  end

  always_comb begin
    IrWrite  = 1'b0;
    PcWrite  = 1'b0;
    PcSrc    = 1'b0;
    alu_op   = ALU_AND;
    Shift    = 1'b0;
    Copy     = 1'b0;
    Load     = 1'b0;
    ReadMem  = 1'b0;
    WriteMem = 1'b0;
    WriteReg = 1'b0;
    Illegal  = 1'b0;
    case (state_q)
      FETCH:  IrWrite = !Halt;
      DECODE: begin
        if (cls == CLS_ILLEGAL) begin
          Illegal = 1'b1;
          PcWrite = 1'b1;
        end
      end
      EXEC: begin
        alu_op = dec_alu_op;
        Shift  = dec_shift;
        Copy   = dec_copy;
        if (cls == CLS_BRANCH) begin
          PcWrite = 1'b1;
          PcSrc   = BranchTaken;
        end
      end
      MEM: begin
        ReadMem  = dec_load;
        WriteMem = !dec_load;
        PcWrite  = MemReady && !dec_load;
      end
      WB: begin
        WriteReg = 1'b1;
        Load     = dec_load;
        PcWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ALUOp      = ALUOP_W'(alu_op);
  assign Busy       = busy;
  assign Done       = (state_q == DONE);
  assign CycleCount = cyc_q;

endmodule

// File: tb/tb_multicycle_ctrl_seq.sv
// Directed bench: a per-cycle vector table for the default build, plus hand-written sequences
// on a second instance (OPCODE_W=4, CYC_W=4) for the illegal-opcode and counter-saturation cases.
module tb_multicycle_ctrl_seq;

  // Expected-output bit positions: {IrWrite, PcWrite, PcSrc, ALUOp[1:0], Shift, Copy, Load,
  //                                 ReadMem, WriteMem, WriteReg, Illegal, Busy, Done}
  localparam logic [13:0] E_IR      = 14'h2000;
  localparam logic [13:0] E_PCW     = 14'h1000;
  localparam logic [13:0] E_PCSRC   = 14'h0800;
  localparam logic [13:0] E_ALU_ADD = 14'h0200;
  localparam logic [13:0] E_ALU_XOR = 14'h0400;
  localparam logic [13:0] E_ALU_CMP = 14'h0600;
  localparam logic [13:0] E_SHIFT   = 14'h0100;
  localparam logic [13:0] E_COPY    = 14'h0080;
  localparam logic [13:0] E_LOAD    = 14'h0040;
  localparam logic [13:0] E_RD      = 14'h0020;
  localparam logic [13:0] E_WR      = 14'h0010;
  localparam logic [13:0] E_WREG    = 14'h0008;
  localparam logic [13:0] E_ILL     = 14'h0004;
  localparam logic [13:0] E_BUSY    = 14'h0002;
  localparam logic [13:0] E_DONE    = 14'h0001;
  localparam logic [13:0] E_NONE    = 14'h0000;

  typedef struct packed {
    logic        rst;
    logic        start;
    logic        halt;
    logic [3:0]  op;
    logic        bt;
    logic        mr;
    logic [13:0] exp;
    logic [15:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, start, halt, bt, mr;
  logic [3:0] opcode;

  logic       a_irw, a_pcw, a_pcsrc, a_shift, a_copy, a_load, a_rd, a_wr, a_wreg, a_ill, a_busy, a_done;
  logic [1:0] a_aluop;
  logic [15:0] a_cnt;
  logic       b_irw, b_pcw, b_pcsrc, b_shift, b_copy, b_load, b_rd, b_wr, b_wreg, b_ill, b_busy, b_done;
  logic [1:0] b_aluop;
  logic [3:0] b_cnt;
  logic [13:0] a_vec, b_vec;

  int checks   = 0;
  int failures = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  multicycle_ctrl_seq dut_a (
    .Clk(clk), .Reset(reset), .Start(start), .Halt(halt), .Opcode(opcode[2:0]),
    .BranchTaken(bt), .MemReady(mr),
    .IrWrite(a_irw), .PcWrite(a_pcw), .PcSrc(a_pcsrc), .ALUOp(a_aluop), .Shift(a_shift),
    .Copy(a_copy), .Load(a_load), .ReadMem(a_rd), .WriteMem(a_wr), .WriteReg(a_wreg),
    .Illegal(a_ill), .Busy(a_busy), .Done(a_done), .CycleCount(a_cnt)
  );

  multicycle_ctrl_seq #(.OPCODE_W(4), .ALUOP_W(2), .CYC_W(4)) dut_b (
    .Clk(clk), .Reset(reset), .Start(start), .Halt(halt), .Opcode(opcode),
    .BranchTaken(bt), .MemReady(mr),
    .IrWrite(b_irw), .PcWrite(b_pcw), .PcSrc(b_pcsrc), .ALUOp(b_aluop), .Shift(b_shift),
    .Copy(b_copy), .Load(b_load), .ReadMem(b_rd), .WriteMem(b_wr), .WriteReg(b_wreg),
    .Illegal(b_ill), .Busy(b_busy), .Done(b_done), .CycleCount(b_cnt)
  );

  assign a_vec = {a_irw, a_pcw, a_pcsrc, a_aluop, a_shift, a_copy, a_load,
                  a_rd, a_wr, a_wreg, a_ill, a_busy, a_done};
  assign b_vec = {b_irw, b_pcw, b_pcsrc, b_aluop, b_shift, b_copy, b_load,
                  b_rd, b_wr, b_wreg, b_ill, b_busy, b_done};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic h, input logic [3:0] o,
                       input logic b, input logic m);
    reset  = r;
    start  = s;
    halt   = h;
    opcode = o;
    bt     = b;
    mr     = m;
  endtask

  function automatic vec_t v(input logic r, input logic s, input logic h, input logic [3:0] o,
                             input logic b, input logic m, input logic [13:0] e, input logic [15:0] c);
    vec_t t;
    t.rst = r; t.start = s; t.halt = h; t.op = o; t.bt = b; t.mr = m; t.exp = e; t.cnt = c;
    return t;
  endfunction

  // Next cycle: drive at the falling edge, sample 1 ns later, rising edge follows.
  task automatic step(input logic r, input logic s, input logic h, input logic [3:0] o,
                      input logic b, input logic m);
    @(negedge clk);
    drive(r, s, h, o, b, m);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_ill, n_pcw, n_bad;
    drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("reset a outputs", a_vec, E_NONE);
    check("reset a count", a_cnt, 0);
    check("reset b outputs", b_vec, E_NONE);
    check("reset b count", b_cnt, 0);

    //              rst st hlt op bt mr  expected outputs                          count
    tbl.push_back(v(0, 1, 0, 2, 0, 0, E_NONE,                                   0));  // IDLE, Start
    tbl.push_back(v(0, 0, 0, 2, 0, 0, E_IR | E_BUSY,                            0));  // add FETCH
    tbl.push_back(v(0, 0, 0, 2, 0, 0, E_BUSY,                                   1));  // DECODE
    tbl.push_back(v(0, 0, 0, 5, 0, 0, E_ALU_ADD | E_BUSY,                       2));  // EXEC, IR change ignored
    tbl.push_back(v(0, 0, 0, 5, 0, 0, E_WREG | E_PCW | E_BUSY,                  3));  // WB
    tbl.push_back(v(0, 0, 0, 1, 0, 0, E_IR | E_BUSY,                            4));  // lb FETCH
    tbl.push_back(v(0, 0, 0, 1, 0, 0, E_BUSY,                                   5));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, E_BUSY,                                   6));  // EXEC ALUOp 00
    tbl.push_back(v(0, 0, 0, 1, 0, 0, E_RD | E_BUSY,                            7));  // MEM wait 1
    tbl.push_back(v(0, 1, 0, 1, 0, 0, E_RD | E_BUSY,                            8));  // Start ignored
    tbl.push_back(v(0, 0, 0, 1, 0, 0, E_RD | E_BUSY,                            9));
    tbl.push_back(v(0, 0, 0, 1, 0, 1, E_RD | E_BUSY,                           10));  // MemReady
    tbl.push_back(v(0, 0, 0, 7, 0, 0, E_WREG | E_LOAD | E_PCW | E_BUSY,        11));  // lb WB
    tbl.push_back(v(0, 0, 0, 7, 0, 0, E_IR | E_BUSY,                           12));  // bne FETCH
    tbl.push_back(v(0, 0, 0, 7, 0, 1, E_BUSY,                                  13));  // MemReady ignored
    tbl.push_back(v(0, 0, 0, 7, 1, 0, E_ALU_CMP | E_PCW | E_PCSRC | E_BUSY,    14));  // taken
    tbl.push_back(v(0, 0, 0, 7, 1, 0, E_IR | E_BUSY,                           15));
    tbl.push_back(v(0, 0, 0, 7, 0, 0, E_BUSY,                                  16));
    tbl.push_back(v(0, 0, 0, 7, 0, 0, E_ALU_CMP | E_PCW | E_BUSY,              17));  // not taken
    tbl.push_back(v(0, 0, 0, 0, 0, 0, E_IR | E_BUSY,                           18));  // sb FETCH
    tbl.push_back(v(0, 0, 0, 0, 0, 0, E_BUSY,                                  19));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, E_BUSY,                                  20));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, E_WR | E_BUSY,                           21));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, E_WR | E_PCW | E_BUSY,                   22));  // sb completes
    tbl.push_back(v(0, 0, 0, 3, 0, 0, E_IR | E_BUSY,                           23));  // and
    tbl.push_back(v(0, 0, 0, 3, 0, 0, E_BUSY,                                  24));
    tbl.push_back(v(0, 0, 0, 3, 0, 0, E_BUSY,                                  25));
    tbl.push_back(v(0, 0, 0, 3, 0, 0, E_WREG | E_PCW | E_BUSY,                 26));
    tbl.push_back(v(0, 0, 0, 4, 0, 0, E_IR | E_BUSY,                           27));  // xor
    tbl.push_back(v(0, 0, 0, 4, 0, 0, E_BUSY,                                  28));
    tbl.push_back(v(0, 0, 0, 4, 0, 0, E_ALU_XOR | E_BUSY,                      29));
    tbl.push_back(v(0, 0, 0, 4, 0, 0, E_WREG | E_PCW | E_BUSY,                 30));
    tbl.push_back(v(0, 0, 0, 6, 0, 0, E_IR | E_BUSY,                           31));  // sl
    tbl.push_back(v(0, 0, 0, 6, 0, 0, E_BUSY,                                  32));
    tbl.push_back(v(0, 0, 0, 6, 0, 0, E_SHIFT | E_BUSY,                        33));
    tbl.push_back(v(0, 0, 0, 6, 0, 0, E_WREG | E_PCW | E_BUSY,                 34));
    tbl.push_back(v(0, 0, 0, 5, 0, 0, E_IR | E_BUSY,                           35));  // cpy
    tbl.push_back(v(0, 0, 0, 5, 0, 0, E_BUSY,                                  36));
    tbl.push_back(v(0, 0, 0, 5, 0, 0, E_COPY | E_BUSY,                         37));
    tbl.push_back(v(0, 0, 0, 5, 0, 0, E_WREG | E_PCW | E_BUSY,                 38));
    tbl.push_back(v(0, 0, 1, 5, 0, 0, E_BUSY,                                  39));  // Halt
    tbl.push_back(v(0, 0, 0, 0, 0, 1, E_DONE,                                  40));  // frozen
    tbl.push_back(v(0, 1, 0, 0, 0, 0, E_DONE,                                  40));  // restart
    tbl.push_back(v(0, 0, 0, 0, 0, 0, E_IR | E_BUSY,                            0));  // sb FETCH
    tbl.push_back(v(0, 0, 0, 0, 0, 0, E_BUSY,                                   1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, E_BUSY,                                   2));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, E_WR | E_BUSY,                            3));  // MEM 1
    tbl.push_back(v(1, 0, 0, 0, 0, 0, E_WR | E_BUSY,                            4));  // Reset in MEM 2
    tbl.push_back(v(0, 0, 0, 0, 0, 0, E_NONE,                                   0));  // aborted cleanly
    tbl.push_back(v(0, 1, 0, 0, 0, 0, E_NONE,                                   0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, E_BUSY,                                   0));  // FETCH, Halt
    tbl.push_back(v(0, 0, 0, 0, 0, 0, E_DONE,                                   1));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, E_DONE,                                   1));  // Reset beats Start
    tbl.push_back(v(0, 0, 0, 0, 0, 0, E_NONE,                                   0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].start, tbl[i].halt, tbl[i].op, tbl[i].bt, tbl[i].mr);
      check($sformatf("row%0d outputs", i), a_vec, tbl[i].exp);
      check($sformatf("row%0d count", i), a_cnt, tbl[i].cnt);
    end

    // Illegal opcode 9 on the 4-bit build: one Illegal/PcWrite pulse, then Halt.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0);
    n_ill = 0; n_pcw = 0; n_bad = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, (i >= 2), 4'd9, 1'b0, 1'b0);
      if (i == 1) check("illegal decode outputs", b_vec, E_ILL | E_PCW | E_BUSY);
      n_ill += int'(b_ill);
      n_pcw += int'(b_pcw);
      n_bad += int'(b_wreg) + int'(b_wr) + int'(b_rd);
    end
    check("illegal pulse count", n_ill, 1);
    check("illegal pcwrite count", n_pcw, 1);
    check("illegal stray strobes", n_bad, 0);
    check("illegal ends in done", b_done, 1);
    check("illegal busy cycles", b_cnt, 3);

    // Five adds with Start held high while busy, then Halt: counter saturates at 15.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic [13:0] e;
      case (i % 4)
        0:       e = E_IR | E_BUSY;
        1:       e = E_BUSY;
        2:       e = E_ALU_ADD | E_BUSY;
        default: e = E_WREG | E_PCW | E_BUSY;
      endcase
      step(1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
      check($sformatf("sat cycle%0d outputs", i), b_vec, e);
      check($sformatf("sat cycle%0d count", i), b_cnt, (i < 15) ? i : 15);
    end
    step(1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
    check("sat halt fetch", b_vec, E_BUSY);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0);
      check($sformatf("sat done%0d outputs", i), b_vec, E_DONE);
      check($sformatf("sat done%0d count", i), b_cnt, 15);
    end
    step(1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
    check("sat start in done", b_cnt, 15);
    step(1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0);
    check("sat restart outputs", b_vec, E_IR | E_BUSY);
    check("sat restart count", b_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
